// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions for the IF/ID stage register.
//   - state_e : occupancy state of the stage register (EMPTY / FULL / SKID)
//   - IFID_*  : bit offsets and widths of the fields in the IF/ID payload
//               {target_pc, next_pc, pc, insn}; the insn field sits at bit 0.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    localparam int IFID_INSN_W   = 32;
    localparam int IFID_PC_W     = 64;
    localparam int IFID_INSN_LSB = 0;
    localparam int IFID_PC_LSB   = IFID_INSN_LSB + IFID_INSN_W;
    localparam int IFID_NPC_LSB  = IFID_PC_LSB + IFID_PC_W;
    localparam int IFID_TGT_LSB  = IFID_NPC_LSB + IFID_PC_W;
    localparam int IFID_W        = IFID_TGT_LSB + IFID_PC_W;   // 224

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter used for backpressure statistics.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (count -> 0)
//   inc_i  : add one this cycle, holding at all-ones
//   clr_i  : force to zero this cycle; wins over inc_i
//   cnt_o  : current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// IF/ID pipeline stage register with optional two-entry skid buffer.
//   clock, reset         : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data payload (zero when
//                          out_valid=0, so an idle stage presents a NOP)
//   flush                : drop everything held, wins over any handshake
//   clr_cnt / stall_cnt  : clear / read the backpressure cycle counter
// SKID=1: in_ready is registered (no combinational out_ready->in_ready path),
//         a second entry absorbs the beat accepted while downstream stalls.
// SKID=0: single register, in_ready = out_ready | !out_valid.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int DATA_W = 224,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              rdy_q, rdy_d;
    logic              in_fire;

    assign in_fire = in_valid & in_ready;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end

    // Next state. Entries are zeroed whenever they are vacated so no stale
    // payload lingers behind an invalid slot.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_ready) begin
                        main_d = in_data;
                    end else if (!in_fire && out_ready) begin
                        main_d  = '0;
                        state_d = ST_EMPTY;
                    end else if (in_fire && (SKID != 0)) begin
                        // Unreachable with SKID=0: in_ready follows out_ready when full.
                        skid_d  = in_data;
                        state_d = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
        // rdy_q is also the "out of reset" flag: 0 in reset, 1 after the first edge.
        rdy_d = (state_d != ST_SKID);
    end

    // Outputs
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        out_data  = out_valid ? main_q : '0;
        if (SKID != 0)
            in_ready = rdy_q;
        else
            in_ready = rdy_q & (out_ready | ~out_valid);
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i  (clock),
        .rst_ni (reset),
        .inc_i  (out_valid & ~out_ready),
        .clr_i  (clr_cnt),
        .cnt_o  (stall_cnt)
    );

endmodule
